// File: rtl/mpc_pkg.sv
// Shared constants, tag/state types and arithmetic helpers for the FCS-MPC
// cost accumulator.
package mpc_pkg;

    localparam int MUL_LAT     = 3;
    localparam int PROD_W      = 22;
    localparam int ACC_W       = 28;
    localparam int IDX_W       = 5;
    localparam int NPC_NUM_VEC = 27;

    typedef struct packed {
        logic valid;
        logic last_term;
        logic last_cand;
    } tag_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // |p| of a signed product; the most negative value maps onto 2^(PROD_W-1)
    function automatic logic [ACC_W-1:0] abs_mag(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] u;
        if (p[PROD_W-1]) begin
            u = ~p + {{(PROD_W-1){1'b0}}, 1'b1};
        end else begin
            u = p;
        end
        return {{(ACC_W-PROD_W){1'b0}}, u};
    endfunction

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return s[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mpc_tag_delay.sv
// Clock-enable-gated tag delay line that tracks the multiplier pipeline so
// each product arrives together with its issue-side tag.
module mpc_tag_delay
    import mpc_pkg::*;
#(
    parameter int DEPTH = MUL_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    // Shift register; frozen whenever the multiplier is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= 3'b000;
            end
        end else if (ce) begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mpc_cost_accum.sv
// Accumulates |weighted error| per candidate switching vector and reports the
// minimum-cost candidate at the end of each frame.
module mpc_cost_accum
    import mpc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic                     in_last_term,
    input  logic                     in_last_cand,
    input  logic signed [PROD_W-1:0] prod,
    output logic                     done,
    output logic [IDX_W-1:0]         best_idx,
    output logic [ACC_W-1:0]         best_cost,
    output logic                     ovf_err
);

    localparam logic [IDX_W-1:0] CNT_MAX = {IDX_W{1'b1}};

    tag_t              tag_in_s;
    tag_t              tag_tap_s;
    logic              consume_s;
    logic [ACC_W-1:0]  mag_s;
    logic [ACC_W-1:0]  sum_s;
    logic [ACC_W-1:0]  acc_base_s;
    logic [ACC_W-1:0]  best_base_s;
    logic [IDX_W-1:0]  idx_base_s;
    logic [IDX_W-1:0]  cnt_base_s;
    logic [ACC_W-1:0]  cmp_cost_s;
    logic [IDX_W-1:0]  cmp_idx_s;

    state_t            state_q,         state_d;
    logic [ACC_W-1:0]  acc_q,           acc_d;
    logic [IDX_W-1:0]  cand_cnt_q,      cand_cnt_d;
    logic [ACC_W-1:0]  best_cost_int_q, best_cost_int_d;
    logic [IDX_W-1:0]  best_idx_int_q,  best_idx_int_d;
    logic [ACC_W-1:0]  best_cost_q,     best_cost_d;
    logic [IDX_W-1:0]  best_idx_q,      best_idx_d;
    logic              done_q,          done_d;
    logic              ovf_q,           ovf_d;

    assign tag_in_s = tag_t'({in_valid, in_last_term, in_last_cand});

    mpc_tag_delay #(
        .DEPTH (MUL_LAT)
    ) u_tag_delay (
        .clk   (clk),
        .rst_n (reset),
        .ce    (ce),
        .tag_i (tag_in_s),
        .tag_o (tag_tap_s)
    );

    // Running values; a term consumed in S_IDLE starts a fresh frame
    always_comb begin
        consume_s = ce & tag_tap_s.valid;
        mag_s     = abs_mag(prod);
        if (state_q == S_IDLE) begin
            acc_base_s  = {ACC_W{1'b0}};
            best_base_s = {ACC_W{1'b1}};
            idx_base_s  = {IDX_W{1'b0}};
            cnt_base_s  = {IDX_W{1'b0}};
        end else begin
            acc_base_s  = acc_q;
            best_base_s = best_cost_int_q;
            idx_base_s  = best_idx_int_q;
            cnt_base_s  = cand_cnt_q;
        end
        sum_s = sat_add(acc_base_s, mag_s);
        // Strict compare keeps the earlier index on a tie
        if (sum_s < best_base_s) begin
            cmp_cost_s = sum_s;
            cmp_idx_s  = cnt_base_s;
        end else begin
            cmp_cost_s = best_base_s;
            cmp_idx_s  = idx_base_s;
        end
    end

    // Next-state: term consumption, candidate close, frame close
    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        cand_cnt_d      = cand_cnt_q;
        best_cost_int_d = best_cost_int_q;
        best_idx_int_d  = best_idx_int_q;
        best_cost_d     = best_cost_q;
        best_idx_d      = best_idx_q;
        done_d          = 1'b0;
        ovf_d           = ovf_q;
        if (consume_s) begin
            cand_cnt_d      = cnt_base_s;
            best_cost_int_d = best_base_s;
            best_idx_int_d  = idx_base_s;
            if (tag_tap_s.last_term) begin
                acc_d           = {ACC_W{1'b0}};
                best_cost_int_d = cmp_cost_s;
                best_idx_int_d  = cmp_idx_s;
                if (cnt_base_s == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cand_cnt_d = cnt_base_s + {{(IDX_W-1){1'b0}}, 1'b1};
                end
                if (tag_tap_s.last_cand) begin
                    state_d     = S_IDLE;
                    best_cost_d = cmp_cost_s;
                    best_idx_d  = cmp_idx_s;
                    done_d      = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                acc_d   = sum_s;
                state_d = S_RUN;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            acc_q           <= {ACC_W{1'b0}};
            cand_cnt_q      <= {IDX_W{1'b0}};
            best_cost_int_q <= {ACC_W{1'b0}};
            best_idx_int_q  <= {IDX_W{1'b0}};
            best_cost_q     <= {ACC_W{1'b0}};
            best_idx_q      <= {IDX_W{1'b0}};
            done_q          <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            cand_cnt_q      <= cand_cnt_d;
            best_cost_int_q <= best_cost_int_d;
            best_idx_int_q  <= best_idx_int_d;
            best_cost_q     <= best_cost_d;
            best_idx_q      <= best_idx_d;
            done_q          <= done_d;
            ovf_q           <= ovf_d;
        end
    end

    assign done      = done_q;
    assign best_idx  = best_idx_q;
    assign best_cost = best_cost_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_mpc_cost_accum.sv
// Directed bench for mpc_cost_accum with a ce-gated three-stage multiplier
// model feeding prod.
module tb_mpc_cost_accum;

    logic               clk;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_last_term;
    logic               in_last_cand;
    logic signed [21:0] prod;
    logic               done;
    logic [4:0]         best_idx;
    logic [27:0]        best_cost;
    logic               ovf_err;

    logic signed [21:0] din;
    logic signed [21:0] p1, p2, p3;

    typedef struct {
        logic signed [21:0] p;
        logic               lt;
        logic               lc;
    } term_t;

    term_t       q[$];
    logic [4:0]  cap_idx[$];
    logic [27:0] cap_cost[$];
    int          done_seen;
    int          n_checks;
    int          n_fail;

    mpc_cost_accum dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .in_valid     (in_valid),
        .in_last_term (in_last_term),
        .in_last_cand (in_last_cand),
        .prod         (prod),
        .done         (done),
        .best_idx     (best_idx),
        .best_cost    (best_cost),
        .ovf_err      (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: din captured on a ce edge shows up on prod three ce edges later
    always @(posedge clk) begin
        if (ce) begin
            p1 <= din;
            p2 <= p1;
            p3 <= p2;
        end
    end
    assign prod = p3;

    // Capture each frame result just after the edge that raises done
    always @(posedge clk) begin
        #1;
        if (done) begin
            cap_idx.push_back(best_idx);
            cap_cost.push_back(best_cost);
            done_seen++;
        end
    end

    task automatic push(input int p, input bit lt, input bit lc);
        term_t t;
        t.p  = 22'(p);
        t.lt = lt;
        t.lc = lc;
        q.push_back(t);
    endtask

    task automatic issue_all();
        foreach (q[i]) begin
            in_valid     = 1'b1;
            din          = q[i].p;
            in_last_term = q[i].lt;
            in_last_cand = q[i].lc;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid     = 1'b0;
        in_last_term = 1'b0;
        in_last_cand = 1'b0;
        din          = 22'sd0;
        q.delete();
    endtask

    // Waits for the next done; lat counts cycles from last issue to done high
    task automatic wait_done(input string name, input int stall, output int lat);
        int start;
        start = done_seen;
        lat   = 1;
        for (int k = 0; k < 60 && done_seen == start; k++) begin
            ce = (k < stall) ? 1'b0 : 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        ce = 1'b1;
        n_checks++;
        if (done_seen == start) begin
            n_fail++;
            $display("FAIL %s timeout: no done seen within 60 cycles", name);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || done_seen != start + 1) begin
            n_fail++;
            $display("FAIL %s pulse: done=%0b pulses=%0d required done=0 pulses=1",
                     name, done, done_seen - start);
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input int exp_idx, input int exp_cost);
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (best_idx !== 5'(exp_idx)) begin
            n_fail++;
            $display("FAIL %s best_idx: got %0d required %0d", name, best_idx, exp_idx);
        end
        n_checks++;
        if (best_cost !== 28'(exp_cost)) begin
            n_fail++;
            $display("FAIL %s best_cost: got %0d required %0d", name, best_cost, exp_cost);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || best_idx !== 5'd0 || best_cost !== 28'd0 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: done=%0b idx=%0d cost=%0d ovf=%0b required all 0",
                     done, best_idx, best_cost, ovf_err);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_basic();
        push(100, 1'b0, 1'b0); push(-50, 1'b1, 1'b0);
        push(30, 1'b0, 1'b0);  push(20, 1'b1, 1'b0);
        push(-70, 1'b0, 1'b1); push(10, 1'b1, 1'b1);
    endtask

    task automatic test_basic();
        int lat;
        frame_basic();
        issue_all();
        wait_done("basic", 0, lat);
        check_result("basic", lat, 4, 1, 50);
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic ovf_err: got %0b required 0", ovf_err);
        end
    endtask

    task automatic test_ties();
        int lat;
        push(25, 1'b0, 1'b0); push(-15, 1'b1, 1'b0);
        push(-40, 1'b1, 1'b0);
        push(30, 1'b0, 1'b1); push(-30, 1'b1, 1'b1);
        issue_all();
        wait_done("ties", 0, lat);
        check_result("ties", lat, 4, 0, 40);
    endtask

    task automatic test_ce_stall();
        int lat;
        frame_basic();
        issue_all();
        wait_done("ce_stall", 2, lat);
        check_result("ce_stall", lat, 6, 1, 50);
    endtask

    task automatic test_most_negative();
        int lat;
        push(-2097152, 1'b1, 1'b1);
        issue_all();
        wait_done("most_neg", 0, lat);
        check_result("most_neg", lat, 4, 0, 2097152);
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < 130; i++) begin
            push(-2097152, (i == 129), (i == 129));
        end
        issue_all();
        wait_done("saturation", 0, lat);
        check_result("saturation", lat, 4, 0, 268435455);
    endtask

    task automatic test_back_to_back();
        int lat;
        int s0;
        s0 = done_seen;
        push(10, 1'b1, 1'b0); push(20, 1'b1, 1'b1);
        push(7, 1'b0, 1'b0);  push(-8, 1'b1, 1'b0); push(1, 1'b1, 1'b1);
        issue_all();
        wait_done("b2b", 0, lat);
        check_result("b2b frame2", lat, 4, 1, 1);
        n_checks++;
        if (done_seen != s0 + 2 || cap_idx[s0] !== 5'd0 || cap_cost[s0] !== 28'd10) begin
            n_fail++;
            $display("FAIL b2b frame1: pulses=%0d idx=%0d cost=%0d required pulses=2 idx=0 cost=10",
                     done_seen - s0, cap_idx[s0], cap_cost[s0]);
        end
    endtask

    task automatic test_overflow();
        int lat;
        for (int i = 0; i < 32; i++) begin
            push(100 - i, 1'b1, 1'b0);
        end
        push(1, 1'b1, 1'b1);
        issue_all();
        wait_done("overflow", 0, lat);
        check_result("overflow", lat, 4, 31, 1);
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow ovf_err: got %0b required 1", ovf_err);
        end
        push(9, 1'b1, 1'b1);
        issue_all();
        wait_done("ovf_sticky", 0, lat);
        check_result("ovf_sticky", lat, 4, 0, 9);
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky ovf_err: got %0b required 1", ovf_err);
        end
    endtask

    task automatic test_mid_frame_reset();
        int lat;
        int start;
        push(11, 1'b0, 1'b0); push(12, 1'b1, 1'b1);
        issue_all();
        reset = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || best_idx !== 5'd0 || best_cost !== 28'd0 || ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset state: done=%0b idx=%0d cost=%0d ovf=%0b required all 0",
                     done, best_idx, best_cost, ovf_err);
        end
        @(negedge clk);
        reset = 1'b1;
        start = done_seen;
        repeat (6) @(negedge clk);
        n_checks++;
        if (done_seen != start) begin
            n_fail++;
            $display("FAIL midreset spurious done: got %0d pulses required 0", done_seen - start);
        end
        push(5, 1'b1, 1'b0); push(3, 1'b1, 1'b1);
        issue_all();
        wait_done("midreset", 0, lat);
        check_result("midreset", lat, 4, 1, 3);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        done_seen    = 0;
        ce           = 1'b1;
        in_valid     = 1'b0;
        in_last_term = 1'b0;
        in_last_cand = 1'b0;
        din          = 22'sd0;
        reset        = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ties();
        test_ce_stall();
        test_most_negative();
        test_saturation();
        test_back_to_back();
        test_overflow();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
